clk_ratio_detector: RTL and testbench

Measures the division ratio of a divided clock that was generated synchronously from `clk` and locks onto it. It reports the period and high time in `clk` cycles and maps the locked ratio back onto the 2-bit divider select code (2→00, 4→01, 8→10, 3→11). It sits on the receiving side of the clock-divider output and is used for self-check of the divider selection and for recovering the select code on a board where only the divided clock is visible.

---
 rtl/clk_ratio_detector.sv | 211 +++++++++++++++++++++
 tb/tb_clk_ratio_detector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_detector.sv
`default_nettype none
// ============================================================================
// Module   : clk_ratio_detector
// Brief    : Measures the period (and optionally the high time) of a divided
//            clock that is synchronous to clk. Locks after LOCK_CNT identical
//            periods and maps the locked ratio back onto the 2-bit divider
//            select code (2->00, 4->01, 8->10, 3->11).
// Option   : CLK_RATIO_DUTY_EN - when defined, the high time is measured and
//            must also be stable for lock; when undefined o_high_cycles is 0.
// Revision : 1.0 - initial release
// ============================================================================
module clk_ratio_detector #(
  parameter int MAX_DIV  = 16,
  parameter int LOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_div_clk_in,
  output logic [4:0] o_ratio,
  output logic [4:0] o_high_cycles,
  output logic       o_locked,
  output logic [1:0] o_sel_code,
  output logic       o_sel_valid,
  output logic       o_lock_lost,
  output logic       o_timeout
);

  localparam logic [4:0] c_max_div  = 5'(MAX_DIV);
  localparam logic [2:0] c_lock_cnt = 3'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_div_d;
  logic       w_rise;
  logic       w_fall;
  logic [4:0] r_per_cnt;
  logic [4:0] w_per_cnt_nxt;
  logic [4:0] r_last_per;
  logic [4:0] w_last_per_nxt;
  logic [2:0] r_match_cnt;
  logic [2:0] w_match_cnt_nxt;
  logic [4:0] w_ratio_nxt;
  logic       w_lock_lost_nxt;
  logic       w_timeout_nxt;
  logic [1:0] w_sel_code_nxt;
  logic       w_sel_valid_nxt;
  logic       w_high_ok;

  // Edge detection on the (already synchronous) divided clock.
  assign w_rise = i_div_clk_in & ~r_div_d;
  assign w_fall = ~i_div_clk_in & r_div_d;

`ifdef CLK_RATIO_DUTY_EN
  logic [4:0] r_high_cnt;
  logic [4:0] r_last_high;

  // High-time counter restarts at each rise, latched into o_high_cycles on fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_high_cnt    <= 5'd0;
      o_high_cycles <= 5'd0;
    end else begin
      if (w_rise) begin
        r_high_cnt <= 5'd1;
      end else if (i_div_clk_in && (r_high_cnt != 5'd31)) begin
        r_high_cnt <= r_high_cnt + 5'd1;
      end
      if (w_fall) begin
        o_high_cycles <= r_high_cnt;
      end
    end
  end

  // High time of the previous period; a fresh acquisition starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_high <= 5'd0;
    end else if (w_rise) begin
      r_last_high <= (r_state == S_IDLE) ? 5'd0 : o_high_cycles;
    end
  end

  assign w_high_ok = (o_high_cycles == r_last_high);
`else
  assign o_high_cycles = 5'd0;
  assign w_high_ok     = 1'b1;
`endif

  // Next-state, period measurement and lock decision.
  always_comb begin
    w_state_nxt     = r_state;
    w_per_cnt_nxt   = r_per_cnt;
    w_last_per_nxt  = r_last_per;
    w_match_cnt_nxt = r_match_cnt;
    w_ratio_nxt     = o_ratio;
    w_lock_lost_nxt = 1'b0;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_per_cnt_nxt = 5'd0;
        if (w_rise) begin
          w_state_nxt     = S_ACQ;
          w_per_cnt_nxt   = 5'd1;
          w_match_cnt_nxt = 3'd0;
          w_last_per_nxt  = 5'd0;
        end
      end
      S_ACQ: begin
        w_per_cnt_nxt = r_per_cnt + 5'd1;
        if (w_rise) begin
          // A rise coinciding with per_cnt == MAX_DIV is a valid period.
          w_per_cnt_nxt  = 5'd1;
          w_last_per_nxt = r_per_cnt;
          if ((r_per_cnt == r_last_per) && w_high_ok) begin
            w_match_cnt_nxt = r_match_cnt + 3'd1;
          end else begin
            w_match_cnt_nxt = 3'd1;
          end
          if (w_match_cnt_nxt == c_lock_cnt) begin
            w_state_nxt = S_LOCKED;
            w_ratio_nxt = r_per_cnt;
          end
        end else if (r_per_cnt == c_max_div) begin
          w_timeout_nxt   = 1'b1;
          w_state_nxt     = S_IDLE;
          w_per_cnt_nxt   = 5'd0;
          w_match_cnt_nxt = 3'd0;
          w_ratio_nxt     = 5'd0;
        end
      end
      S_LOCKED: begin
        w_per_cnt_nxt = r_per_cnt + 5'd1;
        if (w_rise) begin
          w_per_cnt_nxt = 5'd1;
          if ((r_per_cnt != o_ratio) || !w_high_ok) begin
            // Mismatching period counts as the first of a new acquisition.
            w_lock_lost_nxt = 1'b1;
            w_state_nxt     = S_ACQ;
            w_last_per_nxt  = r_per_cnt;
            w_match_cnt_nxt = 3'd1;
            w_ratio_nxt     = 5'd0;
          end
        end else if (r_per_cnt == c_max_div) begin
          w_timeout_nxt   = 1'b1;
          w_state_nxt     = S_IDLE;
          w_per_cnt_nxt   = 5'd0;
          w_match_cnt_nxt = 3'd0;
          w_ratio_nxt     = 5'd0;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_per_cnt_nxt   = 5'd0;
        w_match_cnt_nxt = 3'd0;
        w_ratio_nxt     = 5'd0;
      end
    endcase
  end

  // Map the next ratio onto the divider select code.
  always_comb begin
    w_sel_code_nxt  = 2'b00;
    w_sel_valid_nxt = 1'b0;
    if (w_state_nxt == S_LOCKED) begin
      case (w_ratio_nxt)
        5'd2: begin w_sel_code_nxt = 2'b00; w_sel_valid_nxt = 1'b1; end
        5'd4: begin w_sel_code_nxt = 2'b01; w_sel_valid_nxt = 1'b1; end
        5'd8: begin w_sel_code_nxt = 2'b10; w_sel_valid_nxt = 1'b1; end
        5'd3: begin w_sel_code_nxt = 2'b11; w_sel_valid_nxt = 1'b1; end
        default: begin w_sel_code_nxt = 2'b00; w_sel_valid_nxt = 1'b0; end
      endcase
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_div_d     <= 1'b0;
      r_per_cnt   <= 5'd0;
      r_last_per  <= 5'd0;
      r_match_cnt <= 3'd0;
      o_ratio     <= 5'd0;
      o_locked    <= 1'b0;
      o_sel_code  <= 2'b00;
      o_sel_valid <= 1'b0;
      o_lock_lost <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div_d     <= i_div_clk_in;
      r_per_cnt   <= w_per_cnt_nxt;
      r_last_per  <= w_last_per_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      o_ratio     <= w_ratio_nxt;
      o_locked    <= (w_state_nxt == S_LOCKED);
      o_sel_code  <= w_sel_code_nxt;
      o_sel_valid <= w_sel_valid_nxt;
      o_lock_lost <= w_lock_lost_nxt;
      o_timeout   <= w_timeout_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_ratio_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_ratio_detector
// Brief    : Directed self-checking bench for clk_ratio_detector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_ratio_detector;

  logic       clk;
  logic       rst_n;
  logic       i_div;
  logic [4:0] o_ratio;
  logic [4:0] o_high_cycles;
  logic       o_locked;
  logic [1:0] o_sel_code;
  logic       o_sel_valid;
  logic       o_lock_lost;
  logic       o_timeout;

  int checks   = 0;
  int failures = 0;

`ifdef CLK_RATIO_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  clk_ratio_detector #(.MAX_DIV(16), .LOCK_CNT(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_div_clk_in (i_div),
    .o_ratio      (o_ratio),
    .o_high_cycles(o_high_cycles),
    .o_locked     (o_locked),
    .o_sel_code   (o_sel_code),
    .o_sel_valid  (o_sel_valid),
    .o_lock_lost  (o_lock_lost),
    .o_timeout    (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of input, advance through the edge, settle 1 time unit.
  task automatic tick(input logic v);
    i_div = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0);
    tick(1'b0);
    rst_n = 1'b1;
    tick(1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(c[0]);
      checks++;
      if ({o_ratio, o_high_cycles, o_locked, o_sel_code, o_sel_valid, o_lock_lost, o_timeout} !== 17'd0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=0", c,
                 {o_ratio, o_high_cycles, o_locked, o_sel_code, o_sel_valid, o_lock_lost, o_timeout});
      end
    end
  endtask

  task automatic test_div4();
    logic [4:0] exp_high;
    do_reset();
    exp_high = DUTY ? 5'd2 : 5'd0;
    for (int c = 0; c <= 15; c++) begin
      tick((c % 4) < 2);
      checks++;
      if (o_locked !== (c >= 12)) begin
        failures++;
        $display("FAIL div4_locked cyc=%0d got=%0b exp=%0b", c, o_locked, (c >= 12));
      end
      checks++;
      if ((o_lock_lost | o_timeout) !== 1'b0) begin
        failures++;
        $display("FAIL div4_pulses cyc=%0d got lost=%0b tmo=%0b exp=0", c, o_lock_lost, o_timeout);
      end
    end
    checks++;
    if (o_ratio !== 5'd4) begin
      failures++; $display("FAIL div4_ratio got=%0d exp=4", o_ratio);
    end
    checks++;
    if ({o_sel_code, o_sel_valid} !== 3'b011) begin
      failures++; $display("FAIL div4_sel got=%b exp=011", {o_sel_code, o_sel_valid});
    end
    checks++;
    if (o_high_cycles !== exp_high) begin
      failures++; $display("FAIL div4_high got=%0d exp=%0d", o_high_cycles, exp_high);
    end
  endtask

  task automatic test_div3_to_div8();
    logic       v;
    logic       exp_locked;
    logic       exp_lost;
    logic [4:0] exp_ratio;
    logic [1:0] exp_code;
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      v = (c < 15) ? ((c % 3) < 2) : (((c - 15) % 8) < 4);
      tick(v);
      exp_lost   = (c == 23);
      exp_locked = ((c >= 9) && (c < 23)) || (c >= 39);
      exp_ratio  = ((c >= 9) && (c < 23)) ? 5'd3 : ((c >= 39) ? 5'd8 : 5'd0);
      exp_code   = ((c >= 9) && (c < 23)) ? 2'b11 : ((c >= 39) ? 2'b10 : 2'b00);
      checks++;
      if (o_lock_lost !== exp_lost) begin
        failures++; $display("FAIL sw_lock_lost cyc=%0d got=%0b exp=%0b", c, o_lock_lost, exp_lost);
      end
      checks++;
      if ({o_locked, o_sel_valid} !== {exp_locked, exp_locked}) begin
        failures++;
        $display("FAIL sw_locked cyc=%0d got=%b exp=%b", c, {o_locked, o_sel_valid}, {exp_locked, exp_locked});
      end
      checks++;
      if ({o_ratio, o_sel_code} !== {exp_ratio, exp_code}) begin
        failures++;
        $display("FAIL sw_ratio cyc=%0d got ratio=%0d code=%b exp ratio=%0d code=%b",
                 c, o_ratio, o_sel_code, exp_ratio, exp_code);
      end
      checks++;
      if (o_timeout !== 1'b0) begin
        failures++; $display("FAIL sw_timeout cyc=%0d got=%0b exp=0", c, o_timeout);
      end
    end
  endtask

  task automatic test_div6();
    logic [4:0] exp_high;
    do_reset();
    exp_high = DUTY ? 5'd3 : 5'd0;
    for (int c = 0; c <= 20; c++) begin
      tick((c % 6) < 3);
      checks++;
      if (o_locked !== (c >= 18)) begin
        failures++; $display("FAIL div6_locked cyc=%0d got=%0b exp=%0b", c, o_locked, (c >= 18));
      end
    end
    checks++;
    if ({o_ratio, o_sel_code, o_sel_valid} !== {5'd6, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL div6_ratio_sel got ratio=%0d code=%b valid=%0b exp ratio=6 code=00 valid=0",
               o_ratio, o_sel_code, o_sel_valid);
    end
    checks++;
    if (o_high_cycles !== exp_high) begin
      failures++; $display("FAIL div6_high got=%0d exp=%0d", o_high_cycles, exp_high);
    end
  endtask

  task automatic test_timeout();
    logic       exp_locked;
    logic [4:0] exp_ratio;
    do_reset();
    for (int c = 0; c <= 9; c++) tick((c % 2) == 0);
    checks++;
    if ({o_locked, o_ratio, o_sel_code, o_sel_valid} !== {1'b1, 5'd2, 2'b00, 1'b1}) begin
      failures++;
      $display("FAIL div2_lock got locked=%0b ratio=%0d code=%b valid=%0b exp 1/2/00/1",
               o_locked, o_ratio, o_sel_code, o_sel_valid);
    end
    // Last rise at cycle 8; input held low from cycle 9 on.
    for (int c = 10; c <= 40; c++) begin
      tick(1'b0);
      exp_locked = (c < 24);
      exp_ratio  = (c < 24) ? 5'd2 : 5'd0;
      checks++;
      if (o_timeout !== (c == 24)) begin
        failures++; $display("FAIL tmo_pulse cyc=%0d got=%0b exp=%0b", c, o_timeout, (c == 24));
      end
      checks++;
      if ({o_locked, o_ratio, o_sel_valid} !== {exp_locked, exp_ratio, exp_locked}) begin
        failures++;
        $display("FAIL tmo_state cyc=%0d got locked=%0b ratio=%0d valid=%0b exp locked=%0b ratio=%0d",
                 c, o_locked, o_ratio, o_sel_valid, exp_locked, exp_ratio);
      end
      checks++;
      if (o_lock_lost !== 1'b0) begin
        failures++; $display("FAIL tmo_lost cyc=%0d got=%0b exp=0", c, o_lock_lost);
      end
    end
  endtask

  task automatic test_period16();
    do_reset();
    for (int c = 0; c <= 50; c++) begin
      tick((c % 16) == 0);
      checks++;
      if (o_timeout !== 1'b0) begin
        failures++; $display("FAIL p16_timeout cyc=%0d got=%0b exp=0", c, o_timeout);
      end
      checks++;
      if (o_locked !== (c >= 48)) begin
        failures++; $display("FAIL p16_locked cyc=%0d got=%0b exp=%0b", c, o_locked, (c >= 48));
      end
    end
    checks++;
    if ({o_ratio, o_sel_code, o_sel_valid} !== {5'd16, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL p16_ratio_sel got ratio=%0d code=%b valid=%0b exp ratio=16 code=00 valid=0",
               o_ratio, o_sel_code, o_sel_valid);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    tick(1'b1);
    checks++;
    if ({o_ratio, o_locked, o_sel_code, o_sel_valid, o_lock_lost, o_timeout} !== 11'd0) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=0",
               {o_ratio, o_locked, o_sel_code, o_sel_valid, o_lock_lost, o_timeout});
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_div = 1'b0;
    test_reset();
    test_div4();
    test_div3_to_div8();
    test_div6();
    test_timeout();
    test_period16();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
